// File: rtl/data_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_ctrl
// Brief    : Word-addressed data RAM with byte enables and a wait-state ack FSM.
// Revision : 1.0
// ============================================================================
module data_ram_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ack_o,
    output logic        stall_req_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] c_wait_init = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       data_q, data_d;
    logic              w_access;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_word_idx;
    logic              w_unused_addr;

    logic [31:0] mem [2**ADDR_W];

    // Byte offset and bits above the array size alias onto the same word.
    assign w_word_idx    = mem_addr_i[ADDR_W+1:2];
    assign w_unused_addr = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_access = 1'b0;
        data_d   = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (mem_ce_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d  = S_ACK;
                        w_access = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = c_wait_init;
                    end
                end
            end
            S_WAIT: begin
                if (!mem_ce_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d  = S_ACK;
                    w_access = 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (w_access && !mem_we_i) begin
            data_d = mem[w_word_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // The array has no reset; gating with rst keeps a held reset from writing.
    assign w_mem_we = w_access & mem_we_i & ~rst;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_sel_i[b]) begin
                    mem[w_word_idx][8*b +: 8] <= mem_data_i[8*b +: 8];
                end
            end
        end
    end

    assign mem_ack_o   = (state_q == S_ACK);
    assign mem_data_o  = data_q;
    assign stall_req_o = mem_ce_i & ~mem_ack_o;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_ctrl
// Brief    : Scoreboard bench for data_ram_ctrl, WAIT_CYCLES=2 and WAIT_CYCLES=0.
// Revision : 1.0
// ============================================================================
module tb_data_ram_ctrl;

    localparam int AW = 10;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce    [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [3:0]  sel   [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        stall [2];

    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        mon_e;
    logic [31:0] mdl [2][1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_ram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[0]), .mem_we_i(we[0]), .mem_addr_i(addr[0]),
        .mem_sel_i(sel[0]), .mem_data_i(wdata[0]), .mem_data_o(rdata[0]),
        .mem_ack_o(ack[0]), .stall_req_o(stall[0])
    );

    data_ram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[1]), .mem_we_i(we[1]), .mem_addr_i(addr[1]),
        .mem_sel_i(sel[1]), .mem_data_i(wdata[1]), .mem_data_o(rdata[1]),
        .mem_ack_o(ack[1]), .stall_req_o(stall[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (1 << AW));
    endfunction

    // Monitor: every ack pops one expectation; outside ack the data bus must be zero.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    if (d == 0) mon_e = q0.pop_front();
                    else        mon_e = q1.pop_front();
                    chk("ack_data", rdata[d], mon_e.data);
                    chk("ack_cycle", cyc, mon_e.cyc);
                end
            end else begin
                chk("idle_data", rdata[d], 32'd0);
            end
        end
    end

    // abort_k > 0: drop ce just before the (abort_k+1)-th edge after the request.
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] dat, input int abort_k);
        int   n;
        int   sc;
        int   acks;
        exp_t e;
        @(negedge clk);
        ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdata[d] = dat;
        if (abort_k > 0) begin
            acks = 0;
            repeat (abort_k) @(posedge clk);
            @(negedge clk);
            if (ack[d]) acks++;
            ce[d] = 1'b0;
            repeat (wc(d) + 3) begin
                @(negedge clk);
                if (ack[d]) acks++;
            end
            chk("abort_no_ack", acks, 32'd0);
            return;
        end
        e.cyc  = cyc + 1 + wc(d);
        e.data = w ? 32'd0 : mdl[d][widx(a)];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        if (w) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mdl[d][widx(a)][8*b +: 8] = dat[8*b +: 8];
            end
        end
        #1;
        n  = 0;
        sc = 0;
        while (!ack[d] && n < 30) begin
            if (stall[d]) sc++;
            @(negedge clk);
            n++;
        end
        chk("ack_seen", ack[d], 1'b1);
        chk("stall_cycles", sc, wc(d) + 1);
        chk("stall_in_ack", stall[d], 1'b0);
        ce[d] = 1'b0;
    endtask

    initial begin
        int          k;
        int          d;
        bit          w;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            ce[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; sel[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ack", ack[i], 1'b0);
            chk("reset_data", rdata[i], 32'd0);
        end
        rst = 1'b0;

        // Basic write/read with two wait states
        txn(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
        txn(0, 0, 32'h10, 4'hF, 32'h0, 0);
        // Byte-lane merge and empty-sel write
        txn(0, 1, 32'h20, 4'hF, 32'h11223344, 0);
        txn(0, 1, 32'h20, 4'b0100, 32'hAABBCCDD, 0);
        txn(0, 0, 32'h20, 4'hF, 32'h0, 0);
        txn(0, 1, 32'h20, 4'b0000, 32'hFFFFFFFF, 0);
        txn(0, 0, 32'h20, 4'b0000, 32'h0, 0);
        // Abort mid-WAIT and on the WAIT->ACK edge
        txn(0, 1, 32'h30, 4'hF, 32'h12345678, 0);
        txn(0, 1, 32'h30, 4'hF, 32'hFFFFFFFF, 1);
        txn(0, 0, 32'h30, 4'hF, 32'h0, 0);
        txn(0, 1, 32'h30, 4'hF, 32'hFFFFFFFF, 2);
        txn(0, 0, 32'h30, 4'hF, 32'h0, 0);

        // Async reset in the middle of a write's wait states
        @(negedge clk);
        ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; sel[0] = 4'hF; wdata[0] = 32'hFFFFFFFF;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait_ack", ack[0], 1'b0);
        chk("rst_wait_data", rdata[0], 32'd0);
        ce[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_ack", ack[0], 1'b0);
        end
        txn(0, 0, 32'h30, 4'hF, 32'h0, 0);

        // Async reset while a read ack is presenting data
        txn(0, 0, 32'h10, 4'hF, 32'h0, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_ack_clear", ack[0], 1'b0);
        chk("rst_data_clear", rdata[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Address aliasing
        txn(0, 1, 32'h1000, 4'hF, 32'h0000CAFE, 0);
        txn(0, 0, 32'h0, 4'hF, 32'h0, 0);
        txn(0, 0, 32'h2, 4'hF, 32'h0, 0);
        txn(0, 0, 32'h3, 4'hF, 32'h0, 0);

        // Zero wait states
        txn(1, 1, 32'h4, 4'hF, 32'hA5A55A5A, 0);
        txn(1, 0, 32'h4, 4'hF, 32'h0, 0);
        txn(1, 1, 32'h4, 4'b1001, 32'h01020304, 0);
        txn(1, 0, 32'h4, 4'hF, 32'h0, 0);

        // Randomized traffic over a small set of aliased words
        for (int dd = 0; dd < 2; dd++) begin
            for (int i = 0; i < 16; i++) begin
                txn(dd, 1, 32'(i << 2), 4'hF, $urandom, 0);
            end
        end
        for (int i = 0; i < 300; i++) begin
            d = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            k = 0;
            if (w && wc(d) > 0 && $urandom_range(0, 7) == 0) k = int'($urandom_range(1, wc(d)));
            txn(d, w, a, 4'($urandom), $urandom, k);
        end

        repeat (5) @(negedge clk);
        chk("queue0_drained", q0.size(), 32'd0);
        chk("queue1_drained", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
